// File: rtl/seg7_ca_scan_to_bin.sv
// Receive side of a 2-digit common-anode 7-segment scan bus. Waits for each digit enable to
// settle, samples and decodes each glyph, and assembles tens/ones into a frame. A 0..99 value
// is published only after it has been decoded identically over several consecutive frames.
module seg7_ca_scan_to_bin #(
  parameter int unsigned SETTLE_CYC    = 2,
  parameter int unsigned STABLE_FRAMES = 3,
  parameter int unsigned TIMEOUT_CYC   = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  input  logic [1:0] dig_en_n,
  output logic [6:0] num_out,
  output logic       num_valid,
  output logic       code_err,
  output logic       scan_lost
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned FW = $clog2(STABLE_FRAMES + 1);
  localparam logic [SW-1:0] SettleMax  = SW'(SETTLE_CYC);
  localparam logic [FW-1:0] StableMax  = FW'(STABLE_FRAMES);
  localparam logic [15:0]   TimeoutMax = 16'(TIMEOUT_CYC);

  typedef enum logic [1:0] {StWaitT, StWaitO, StCheck} state_e;

  // Returns {legal, digit} for an active-low a..g pattern.
  function automatic logic [4:0] decode(input logic [6:0] g);
    unique case (g)
      7'h01:   decode = {1'b1, 4'd0};
      7'h4F:   decode = {1'b1, 4'd1};
      7'h12:   decode = {1'b1, 4'd2};
      7'h06:   decode = {1'b1, 4'd3};
      7'h4C:   decode = {1'b1, 4'd4};
      7'h24:   decode = {1'b1, 4'd5};
      7'h20:   decode = {1'b1, 4'd6};
      7'h0F:   decode = {1'b1, 4'd7};
      7'h00:   decode = {1'b1, 4'd8};
      7'h04:   decode = {1'b1, 4'd9};
      default: decode = {1'b0, 4'd0};
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [1:0]      en_prev_q;
  logic [SW-1:0]   settle_q, settle_d;
  logic [3:0]      tens_q, tens_d, ones_q, ones_d;
  logic [6:0]      cand_q, cand_d, num_q, num_d;
  logic [FW-1:0]   stable_q, stable_d;
  logic            published_q, published_d;
  logic            valid_q, valid_d, err_q, err_d, lost_q, lost_d;
  logic [15:0]     to_q, to_d;
  logic            samp, samp_t, samp_o, enter_check;
  logic [4:0]      dec;
  logic            blank, tens_ok;
  logic [3:0]      tens_val;
  logic [6:0]      value;
  logic            unused_dp;

  assign unused_dp = seg_in[7];
  assign dec       = decode(seg_in[6:0]);
  assign blank     = (seg_in[6:0] == 7'h7F);
  assign tens_ok   = dec[4] | blank;
  assign tens_val  = blank ? 4'd0 : dec[3:0];
  assign value     = 7'(tens_q) * 7'd10 + 7'(ones_q);

  // Settle counter: one sample per stable single-digit enable window.
  always_comb begin
    settle_d = settle_q;
    samp     = 1'b0;
    if (dig_en_n != en_prev_q || dig_en_n == 2'b11 || dig_en_n == 2'b00) begin
      settle_d = '0;
    end else if (settle_q != SettleMax) begin
      settle_d = settle_q + 1'b1;
      samp     = (settle_d == SettleMax);
    end
  end

  assign samp_t = samp & ~dig_en_n[1];
  assign samp_o = samp & ~dig_en_n[0];

  // Frame FSM, stability tracking, publish and timeout next-state.
  always_comb begin
    state_d     = state_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    cand_d      = cand_q;
    stable_d    = stable_q;
    num_d       = num_q;
    published_d = published_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    enter_check = 1'b0;
    to_d        = to_q;
    lost_d      = lost_q;
    case (state_q)
      StWaitT: begin
        if (samp_t) begin
          if (tens_ok) begin
            tens_d  = tens_val;
            state_d = StWaitO;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWaitO: begin
        if (samp_o) begin
          if (dec[4]) begin
            ones_d      = dec[3:0];
            state_d     = StCheck;
            enter_check = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitT;
          end
        end else if (samp_t) begin
          // A newer tens glyph replaces the stored one; a bad one discards the frame.
          if (tens_ok) begin
            tens_d = tens_val;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitT;
          end
        end
      end
      StCheck: begin
        state_d = StWaitT;
        if (value == cand_q) begin
          stable_d = (stable_q == StableMax) ? stable_q : stable_q + 1'b1;
        end else begin
          cand_d   = value;
          stable_d = FW'(1);
        end
        if (stable_d == StableMax && (value != num_q || !published_q)) begin
          num_d       = value;
          valid_d     = 1'b1;
          published_d = 1'b1;
        end
      end
      default: state_d = StWaitT;
    endcase
    if (err_d) stable_d = '0;
    if (enter_check) begin
      to_d   = '0;
      lost_d = 1'b0;
    end else begin
      if (to_q != TimeoutMax) to_d = to_q + 1'b1;
      if (to_d == TimeoutMax) lost_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StWaitT;
      en_prev_q   <= 2'b11;
      settle_q    <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      cand_q      <= '0;
      stable_q    <= '0;
      num_q       <= '0;
      published_q <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      lost_q      <= 1'b0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      en_prev_q   <= dig_en_n;
      settle_q    <= settle_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      num_q       <= num_d;
      published_q <= published_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      lost_q      <= lost_d;
      to_q        <= to_d;
    end
  end

  assign num_out   = num_q;
  assign num_valid = valid_q;
  assign code_err  = err_q;
  assign scan_lost = lost_q;

endmodule

// File: tb/tb_seg7_ca_scan_to_bin.sv
// Scoreboard bench: stimulus pushes expected published values, a negedge monitor pops them
// whenever num_valid pulses and also counts code_err pulses.
module tb_seg7_ca_scan_to_bin;

  localparam int unsigned Timeout = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg_in;
  logic [1:0] dig_en_n;
  logic [6:0] num_out;
  logic       num_valid, code_err, scan_lost;

  int checks  = 0;
  int passes  = 0;
  int err_seen = 0;
  int exp_err  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  seg7_ca_scan_to_bin #(
    .SETTLE_CYC   (2),
    .STABLE_FRAMES(3),
    .TIMEOUT_CYC  (Timeout)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seg_in   (seg_in),
    .dig_en_n (dig_en_n),
    .num_out  (num_out),
    .num_valid(num_valid),
    .code_err (code_err),
    .scan_lost(scan_lost)
  );

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, got, exp);
  endtask

  // Monitor: every publish must match the oldest expected value.
  always @(negedge clk) begin
    if (num_valid) begin
      if (exp_q.size() == 0) check("unexpected_publish", int'(num_out), -1);
      else check("publish_value", int'(num_out), exp_q.pop_front());
    end
    if (code_err) err_seen++;
  end

  task automatic hold(input logic [1:0] en, input logic [7:0] seg, input int n);
    dig_en_n = en;
    seg_in   = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] t, input logic [7:0] o);
    hold(2'b01, t, 4);
    hold(2'b10, o, 4);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    dig_en_n = 2'b11;
    seg_in = 8'hFF;
    repeat (n) @(posedge clk);
    #1;
    check("rst_num_out", int'(num_out), 0);
    check("rst_num_valid", int'(num_valid), 0);
    check("rst_code_err", int'(code_err), 0);
    check("rst_scan_lost", int'(scan_lost), 0);
    rst = 1'b0;
  endtask

  task automatic settle_out(input string name);
    hold(2'b11, 8'hFF, 5);
    check(name, exp_q.size(), 0);
    check("code_err_count", err_seen, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    seg_in = 8'hFF;
    dig_en_n = 2'b11;
    @(posedge clk);
    #1;

    // 1: "42" three times publishes once.
    do_reset(2);
    frame(8'hCC, 8'h92);
    frame(8'hCC, 8'h92);
    exp_q.push_back(42);
    frame(8'hCC, 8'h92);
    settle_out("t1_pending");
    check("t1_num_out", int'(num_out), 42);

    // 2: 42,42 never stabilises; 17 x3 publishes.
    do_reset(2);
    frame(8'hCC, 8'h92);
    frame(8'hCC, 8'h92);
    frame(8'hCF, 8'h8F);
    frame(8'hCF, 8'h8F);
    exp_q.push_back(17);
    frame(8'hCF, 8'h8F);
    settle_out("t2_pending");
    check("t2_num_out", int'(num_out), 17);

    // 3: illegal ones glyph restarts the stable count.
    do_reset(2);
    frame(8'hCC, 8'h92);
    frame(8'hCC, 8'hFF);
    exp_err++;
    frame(8'hCC, 8'h92);
    frame(8'hCC, 8'h92);
    exp_q.push_back(42);
    frame(8'hCC, 8'h92);
    frame(8'hCC, 8'hAA);
    exp_err++;
    frame(8'hCC, 8'h92);
    frame(8'hCC, 8'h92);
    frame(8'hCC, 8'h92);
    settle_out("t3_pending");
    check("t3_num_out", int'(num_out), 42);

    // 4: unsettled/conflicting enables lose the scan; a good frame restores it.
    do_reset(2);
    for (int i = 0; i < 60; i++) hold((i % 2) ? 2'b01 : 2'b10, 8'hCC, 1);
    check("t4_lost_early", int'(scan_lost), 0);
    hold(2'b00, 8'hCC, 60);
    check("t4_lost", int'(scan_lost), 1);
    frame(8'hCC, 8'h92);
    check("t4_recovered", int'(scan_lost), 0);
    settle_out("t4_pending");

    // 5: blank tens and dp ignored.
    do_reset(2);
    frame(8'hFF, 8'hA4);
    frame(8'hFF, 8'h24);
    exp_q.push_back(5);
    frame(8'hFF, 8'hA4);
    settle_out("t5_pending");
    check("t5_num_out", int'(num_out), 5);

    // 6: reset in WAIT_O of frame 3 discards progress.
    do_reset(2);
    frame(8'hCC, 8'h92);
    frame(8'hCC, 8'h92);
    hold(2'b01, 8'hCC, 4);
    do_reset(1);
    frame(8'hCC, 8'h92);
    frame(8'hCC, 8'h92);
    check("t6_no_early", int'(num_out), 0);
    exp_q.push_back(42);
    frame(8'hCC, 8'h92);
    settle_out("t6_pending");
    check("t6_num_out", int'(num_out), 42);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
